// File: rtl/goc_pwm_tx_if.sv
// Byte-stream enqueue port of the GOC transmitter: data, frame-end marker,
// valid/ready handshake.
interface goc_pwm_tx_if;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_last, output in_valid, input in_ready);
    modport slave  (input in_data, input in_last, input in_valid, output in_ready);
endinterface

// File: rtl/goc_pwm_tx.sv
// GOC optical programming transmitter: FWFT byte FIFO feeding an MSB-first
// serialiser with PWM or Manchester line coding and quarter-bit timing.
//
// state | meaning
// IDLE  | line at idle level, waiting for start_tx with a non-empty FIFO
// SHIFT | frame in progress, one byte in the shift register
module goc_pwm_tx #(
    parameter int SPEED_W = 22,
    parameter int DEPTH   = 16,
    parameter int AW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] goc_speed,
    input  logic               goc_polarity,
    input  logic               goc_mode,
    goc_pwm_tx_if.slave        in_if,
    input  logic               start_tx,
    input  logic               abort,
    output logic               busy,
    output logic               tx_done,
    output logic               tx_err,
    output logic [AW:0]        fifo_level,
    output logic               GOC_PAD
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [8:0]         mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [7:0]         shift_q, shift_d;
    logic               last_q, last_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [SPEED_W-1:0] cnt_q, cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               mode_q, mode_d;
    logic               pol_q, pol_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               pad_q, pad_d;
    logic               raw_d;
    logic               push, pop, flush, fifo_empty;
    logic [8:0]         head;

    // Raw level of quarter q of a bit cell carrying value b.
    function automatic logic line_code(input logic b, input logic [1:0] q, input logic m);
        if (m) return b ? ~q[1] : q[1];
        else   return b ? (q != 2'd3) : (q == 2'd0);
    endfunction

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign in_if.in_ready = (level_q != (AW+1)'(DEPTH));
    assign push       = in_if.in_valid & in_if.in_ready & ~abort;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        bit_d   = bit_q;
        qtr_d   = qtr_q;
        cnt_d   = cnt_q;
        speed_d = speed_q;
        mode_d  = mode_q;
        pol_d   = pol_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    flush = 1'b1;
                end else if (start_tx && !fifo_empty) begin
                    state_d = SHIFT;
                    speed_d = goc_speed;
                    mode_d  = goc_mode;
                    pol_d   = goc_polarity;
                    {last_d, shift_d} = head;
                    pop     = 1'b1;
                    bit_d   = 3'd7;
                    qtr_d   = 2'd0;
                    cnt_d   = goc_speed;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = speed_q;
                    if (qtr_q != 2'd3) begin
                        qtr_d = qtr_q + 2'd1;
                    end else begin
                        qtr_d = 2'd0;
                        if (bit_q != 3'd0) begin
                            bit_d = bit_q - 3'd1;
                        end else if (last_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (!fifo_empty) begin
                            // Next byte follows with no gap cycles.
                            {last_d, shift_d} = head;
                            pop   = 1'b1;
                            bit_d = 3'd7;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
            level_d  = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Pad is registered from next-state values so the first quarter appears
    // in the cycle right after start_tx is accepted.
    always_comb begin
        raw_d = (state_d == SHIFT) && line_code(shift_d[bit_d], qtr_d, mode_d);
        pad_d = (state_d == SHIFT) ? (raw_d ^ pol_d) : goc_polarity;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_if.in_last, in_if.in_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            shift_q  <= '0;
            last_q   <= 1'b0;
            bit_q    <= '0;
            qtr_q    <= '0;
            cnt_q    <= '0;
            speed_q  <= '0;
            mode_q   <= 1'b0;
            pol_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pad_q    <= goc_polarity;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            bit_q    <= bit_d;
            qtr_q    <= qtr_d;
            cnt_q    <= cnt_d;
            speed_q  <= speed_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pad_q    <= pad_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign fifo_level = level_q;
    assign GOC_PAD    = pad_q;

endmodule

// File: tb/tb_goc_pwm_tx.sv
// Self-checking bench for goc_pwm_tx: table-driven frames, hand-written
// corner sequences and random frames against a waveform-level model.
module tb_goc_pwm_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] goc_speed;
    logic        goc_polarity;
    logic        goc_mode;
    logic        start_tx;
    logic        abort;
    logic        busy, tx_done, tx_err, GOC_PAD;
    logic [4:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fb[$];

    goc_pwm_tx_if s_if ();

    goc_pwm_tx dut (
        .clk          (clk),
        .reset        (reset),
        .goc_speed    (goc_speed),
        .goc_polarity (goc_polarity),
        .goc_mode     (goc_mode),
        .in_if        (s_if),
        .start_tx     (start_tx),
        .abort        (abort),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_err       (tx_err),
        .fifo_level   (fifo_level),
        .GOC_PAD      (GOC_PAD)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             spd;
        bit             md;
        bit             pl;
        int             nb;
        logic [3:0][7:0] d;
        bit             underrun;
        int             exp_len;
        bit             exp_err;
        int             chg_at;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        s_if.in_data  = d;
        s_if.in_last  = last;
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
    endtask

    // Expected pad level per clock, straight from the line-coding rules.
    function automatic void build_wave(input int spd, input bit md, input bit pl, output logic w[$]);
        w.delete();
        foreach (fb[k])
            for (int b = 7; b >= 0; b--)
                for (int q = 0; q < 4; q++)
                    for (int r = 0; r <= spd; r++) begin
                        logic v;
                        logic raw;
                        v = fb[k][b];
                        if (md) raw = v ? (q < 2) : (q >= 2);
                        else    raw = v ? (q < 3) : (q == 0);
                        w.push_back(raw ^ pl);
                    end
    endfunction

    task automatic run_frame(input string nm, input int spd, input bit md, input bit pl,
                             input bit underrun, input int exp_len, input bit exp_err, input int chg_at);
        logic w[$];
        int   bad;
        int   early;
        int   first_bad;
        int   waited;
        goc_speed    = 22'(spd);
        goc_mode     = md;
        goc_polarity = pl;
        foreach (fb[k]) push_byte(fb[k], !underrun && (k == fb.size() - 1));
        check({nm, "_level"}, 32'(fifo_level), 32'(fb.size()));
        build_wave(spd, md, pl, w);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        check({nm, "_busy_rise"}, 32'(busy), 32'd1);
        bad = 0;
        early = 0;
        first_bad = -1;
        for (int i = 0; i < exp_len; i++) begin
            if (i >= w.size() || GOC_PAD !== w[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (tx_done || !busy) early++;
            if (i == chg_at) begin
                goc_speed    = 22'(spd + 2);
                goc_mode     = ~md;
                goc_polarity = ~pl;
            end
            tick();
        end
        if (bad != 0) $display("  %s first pad difference at clock %0d", nm, first_bad);
        check({nm, "_pad_wave_bad_cycles"}, 32'(bad), 32'd0);
        check({nm, "_early_end"}, 32'(early), 32'd0);
        check({nm, "_tx_done"}, 32'(tx_done), 32'd1);
        check({nm, "_tx_err"}, 32'(tx_err), 32'(exp_err));
        check({nm, "_busy_fall"}, 32'(busy), 32'd0);
        check({nm, "_pad_idle"}, 32'(GOC_PAD), 32'(goc_polarity));
        check({nm, "_level_end"}, 32'(fifo_level), 32'd0);
        if (tx_done !== 1'b1) begin
            waited = 0;
            while (tx_done !== 1'b1 && waited < 400) begin
                tick();
                waited++;
            end
            if (busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
        end
        tick();
        check({nm, "_done_pulse"}, 32'(tx_done), 32'd0);
        fb.delete();
    endtask

    initial begin
        vec_t tbl[5];
        int   seen;

        tbl[0] = '{1, 1'b0, 1'b0, 1, 32'h000000A5, 1'b0, 64,  1'b0, -1};
        tbl[1] = '{0, 1'b1, 1'b1, 2, 32'h0000FF3C, 1'b0, 64,  1'b0, -1};
        tbl[2] = '{0, 1'b0, 1'b0, 1, 32'h00000012, 1'b1, 32,  1'b1, -1};
        tbl[3] = '{2, 1'b1, 1'b0, 3, 32'h00007E81, 1'b0, 288, 1'b0, 50};
        tbl[4] = '{0, 1'b0, 1'b1, 4, 32'hDEADBEEF, 1'b1, 128, 1'b1, -1};

        reset = 1'b1;
        goc_speed = '0;
        goc_polarity = 1'b1;
        goc_mode = 1'b0;
        start_tx = 1'b0;
        abort = 1'b0;
        s_if.in_data = '0;
        s_if.in_last = 1'b0;
        s_if.in_valid = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(s_if.in_ready), 32'd1);
        check("rst_pad", 32'(GOC_PAD), 32'(goc_polarity));
        reset = 1'b0;
        tick();

        // start_tx with an empty FIFO is ignored
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        check("empty_start_busy", 32'(busy), 32'd0);
        tick();
        check("empty_start_done", 32'(tx_done), 32'd0);

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < tbl[t].nb; k++) fb.push_back(tbl[t].d[k]);
            run_frame($sformatf("vec%0d", t), tbl[t].spd, tbl[t].md, tbl[t].pl,
                      tbl[t].underrun, tbl[t].exp_len, tbl[t].exp_err, tbl[t].chg_at);
        end

        // FIFO full, dropped 17th push, in_ready returns after first pop
        goc_speed = '0;
        goc_polarity = 1'b0;
        for (int k = 0; k < 16; k++) push_byte(8'(k + 8'h40), 1'b0);
        check("full_ready", 32'(s_if.in_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd16);
        push_byte(8'hEE, 1'b1);
        check("full_drop_level", 32'(fifo_level), 32'd16);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        check("full_pop_level", 32'(fifo_level), 32'd15);
        check("full_pop_ready", 32'(s_if.in_ready), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("full_abort_level", 32'(fifo_level), 32'd0);
        tick();

        // Abort mid-bit with 5 bytes queued and a coincident push
        goc_speed = 22'd3;
        goc_polarity = 1'b1;
        for (int k = 0; k < 5; k++) push_byte(8'(8'h90 + k), k == 4);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        s_if.in_data = 8'h55;
        s_if.in_valid = 1'b1;
        tick();
        abort = 1'b0;
        s_if.in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(tx_done), 32'd1);
        check("abort_err", 32'(tx_err), 32'd1);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_pad", 32'(GOC_PAD), 32'(goc_polarity));
        tick();
        check("abort_done_pulse", 32'(tx_done), 32'd0);

        // Abort in IDLE flushes without tx_done
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_level", 32'(fifo_level), 32'd0);
        check("idle_abort_done", 32'(tx_done), 32'd0);

        // Reset mid-frame
        goc_speed = 22'd1;
        goc_polarity = 1'b0;
        for (int k = 0; k < 3; k++) push_byte(8'(8'hC0 + k), k == 2);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(tx_done), 32'd0);
        check("mrst_err", 32'(tx_err), 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_ready", 32'(s_if.in_ready), 32'd1);
        check("mrst_pad", 32'(GOC_PAD), 32'(goc_polarity));
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx_done || busy) seen++;
        end
        check("mrst_no_activity", 32'(seen), 32'd0);

        // Random frames against the waveform model
        for (int r = 0; r < 12; r++) begin
            int spd;
            int nb;
            bit ur;
            spd = $urandom_range(0, 3);
            nb  = $urandom_range(1, 4);
            ur  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < nb; k++) fb.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", r), spd, 1'($urandom), 1'($urandom),
                      ur, nb * 32 * (spd + 1), ur, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
